// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HALT
  } fetch_state_t;

  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs.
// A flush empties it and wins over push and pop. A push is accepted
// while full only if a pop happens in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_doPush;
  logic          w_doPop;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign dout     = r_mem[r_head];
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);

  // Storage writes; the entry contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (!reset && !flush && w_doPush) begin
      r_mem[r_tail] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_doPop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + CW'(1);
      end else if (w_doPop && !w_doPush) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, captures words from the
// asynchronous-read instruction memory into a prefetch queue, serves decode
// over valid/ready, flushes on redirect and parks after an ECALL.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        misalign_err
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t  r_state;
  fetch_state_t  w_nextState;
  logic [31:0]   r_fetchPc;
  logic          r_halted;
  logic          r_misalign;

  logic          w_push;
  logic          w_pop;
  logic          w_isEcall;
  fetch_entry_t  w_din;
  fetch_entry_t  w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;

  assign imem_addr    = r_fetchPc;
  assign out_valid    = !w_empty;
  assign out_inst     = w_head.inst;
  assign out_pc       = w_head.pc;
  assign halted       = r_halted;
  assign misalign_err = r_misalign;

  assign w_pop     = out_valid && out_ready;
  assign w_isEcall = (imem_dout == INST_ECALL);
  assign w_push    = (r_state == FETCH) && ((w_count < CW'(QUEUE_DEPTH)) || w_pop)
                     && !redirect_valid;
  assign w_din     = '{inst: imem_dout, pc: r_fetchPc};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .din   (w_din),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // A full queue can never also be empty.
  assert property (@(posedge clk) disable iff (reset) w_full |-> !w_empty);

  // Next-state logic: a redirect always lands in FETCH, even out of HALT.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      BOOT:    w_nextState = FETCH;
      FETCH:   if (w_push && w_isEcall) w_nextState = HALT;
      HALT:    w_nextState = HALT;
      default: w_nextState = BOOT;
    endcase
    if (redirect_valid) begin
      w_nextState = FETCH;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Fetch PC, halted flag and the sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetchPc  <= RESET_PC;
      r_halted   <= 1'b0;
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_fetchPc <= {redirect_pc[31:2], 2'b00};
      r_halted  <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
      end
    end else if (w_push) begin
      r_fetchPc <= r_fetchPc + 32'd4;
      if (w_isEcall) begin
        r_halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural asynchronous-read memory.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] imemAddr;
  logic [31:0] imemDout;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInst;
  logic [31:0] outPc;
  logic        halted;
  logic        misalignErr;

  logic [31:0] mem [64];
  int          checkCount;
  int          failCount;

  fetch_ctrl #(
    .QUEUE_DEPTH (2),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imemAddr),
    .imem_dout      (imemDout),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .out_valid      (outValid),
    .out_ready      (outReady),
    .out_inst       (outInst),
    .out_pc         (outPc),
    .halted         (halted),
    .misalign_err   (misalignErr)
  );

  assign imemDout = mem[imemAddr[7:2]];

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs for the next rising edge, then advance to the following falling edge.
  task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] rp,
                               input logic rdy);
    reset         = rst;
    redirectValid = rv;
    redirectPc    = rp;
    outReady      = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;

    // Reset state
    reset = 1'b1; redirectValid = 1'b0; redirectPc = '0; outReady = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("rst_valid", {31'b0, outValid}, 32'h0);
    checkOutput("rst_halted", {31'b0, halted}, 32'h0);
    checkOutput("rst_misalign", {31'b0, misalignErr}, 32'h0);
    checkOutput("rst_addr", imemAddr, 32'h0);

    // Streaming after reset: one BOOT cycle then one instruction per cycle
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("boot_valid", {31'b0, outValid}, 32'h0);
    checkOutput("boot_addr", imemAddr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("s0_valid", {31'b0, outValid}, 32'h1);
    checkOutput("s0_pc", outPc, 32'h0);
    checkOutput("s0_inst", outInst, 32'h0050_0093);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("s1_pc", outPc, 32'h4);
    checkOutput("s1_inst", outInst, 32'h0010_0113);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("s2_pc", outPc, 32'h8);
    checkOutput("s2_inst", outInst, 32'h0000_0013);

    // Back-pressure: queue fills with 0x0 and 0x4, fetch PC parks at 0x8
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bp_valid", {31'b0, outValid}, 32'h1);
    checkOutput("bp_pc", outPc, 32'h0);
    checkOutput("bp_addr", imemAddr, 32'h8);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("bp_pc1", outPc, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("bp_pc2", outPc, 32'h8);
    checkOutput("bp_addr2", imemAddr, 32'h10);

    // Redirect with 0x8/0xC queued: both discarded, fetch restarts at 0x40
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
    checkOutput("rd_valid", {31'b0, outValid}, 32'h0);
    checkOutput("rd_addr", imemAddr, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rd_pc", outPc, 32'h40);
    checkOutput("rd_misalign", {31'b0, misalignErr}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rd_pc_next", outPc, 32'h44);

    // ECALL at 0x10: delivered, halted asserts, fetch parks at 0x14
    mem[4] = 32'h0000_0073;
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
    checkOutput("ec_flush_valid", {31'b0, outValid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("ec_stream_pc", outPc, 32'(i * 4));
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("ec_pc", outPc, 32'h10);
    checkOutput("ec_inst", outInst, 32'h0000_0073);
    checkOutput("ec_halted", {31'b0, halted}, 32'h1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("halt_addr", imemAddr, 32'h14);
    checkOutput("halt_valid", {31'b0, outValid}, 32'h0);
    checkOutput("halt_halted", {31'b0, halted}, 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1);
    checkOutput("unhalt_halted", {31'b0, halted}, 32'h0);
    checkOutput("unhalt_addr", imemAddr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("unhalt_pc", outPc, 32'h0);
    checkOutput("unhalt_valid", {31'b0, outValid}, 32'h1);

    // Misaligned redirect: aligned fetch, sticky error until reset
    applyStimulus(1'b0, 1'b1, 32'h22, 1'b1);
    checkOutput("mis_err", {31'b0, misalignErr}, 32'h1);
    checkOutput("mis_addr", imemAddr, 32'h20);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mis_pc", outPc, 32'h20);
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b1);
    checkOutput("mis_sticky", {31'b0, misalignErr}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("mis_cleared", {31'b0, misalignErr}, 32'h0);

    // Reset mid-stream with a full queue
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("mr_full_valid", {31'b0, outValid}, 32'h1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("mr_valid", {31'b0, outValid}, 32'h0);
    checkOutput("mr_addr", imemAddr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mr_boot_valid", {31'b0, outValid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mr_first_pc", outPc, 32'h0);
    checkOutput("mr_first_inst", outInst, 32'h0050_0093);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the asynchronous-read instruction memory of the pipelined core. Owns the fetch PC and drives the memory address. Captures each returned word with its PC into a small prefetch queue. Hands instructions to decode over a valid/ready handshake, handles branch/jump redirects with a queue flush, and stops fetching after an ECALL.

Parameters:
QUEUE_DEPTH, 2, prefetch queue entries; power of two, minimum 2.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  single clock.
reset  in  1  synchronous, active-high; instruction memory loads its image while this is high.
imem_addr  out  32  byte address to instruction memory; memory indexes word addr>>2; always equals fetch_pc.
imem_dout  in  32  instruction word at imem_addr, same cycle (asynchronous read).
redirect_valid  in  1  taken branch/jump from execute; one-cycle pulse.
redirect_pc  in  32  new fetch address.
out_valid  out  1  queue head holds an instruction.
out_ready  in  1  decode accepts the head this cycle.
out_inst  out  32  head instruction.
out_pc  out  32  head PC.
halted  out  1  ECALL has been enqueued; fetch is stopped.
misalign_err  out  1  sticky; a redirect_pc had bits [1:0] != 0.

Behaviour:
- States: BOOT, FETCH, HALT.
- Reset, synchronous, highest priority, valid mid-operation:
  - state=BOOT, fetch_pc=RESET_PC, queue count=0, head/tail=0.
  - halted=0, misalign_err=0, out_valid=0.
- BOOT: lasts exactly one cycle after reset falls and gives the memory image one settled cycle. No enqueue. Next state is FETCH. A redirect in BOOT is honoured: it loads fetch_pc and the state still goes to FETCH.
- FETCH, push condition: push = (count<QUEUE_DEPTH or pop) and !redirect_valid.
- FETCH, on push:
  - Enqueue {imem_dout, fetch_pc}.
  - fetch_pc <= fetch_pc+4, wrapping modulo 2^32.
- FETCH, ECALL: if the pushed word equals 32'h0000_0073, the state goes to HALT next cycle. The ECALL itself is enqueued.
- Pop: pop = out_valid && out_ready. The head advances next cycle.
- Full queue with a pop in the same cycle: the push still occurs and count is unchanged.
- Empty queue: out_valid=0. out_inst and out_pc are don't-care.
- Queue latency: a word pushed in cycle N is visible at the head in cycle N+1. There is no combinational bypass from imem_dout to out_inst.
- Redirect, when redirect_valid=1 in any non-reset state; it has priority over push and ECALL:
  - count<=0 and head/tail<=0; all queued entries are discarded.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - state <= FETCH, leaving HALT if applicable.
  - halted <= 0.
  - If redirect_pc[1:0]!=0, misalign_err <= 1. It clears only on reset.
- A handshake in the redirect cycle is a completed transfer, and decode owns that instruction. out_valid is not gated by redirect_valid.
- HALT:
  - No push.
  - Queued entries, including the ECALL, continue to drain via the handshake.
  - halted=1 is registered and asserts the cycle after ECALL enters the queue.
  - HALT exits only on redirect or reset.
- count width is clog2(QUEUE_DEPTH)+1. Pointers wrap modulo QUEUE_DEPTH.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {BOOT, FETCH, HALT}.
  - INST_ECALL = 32'h0000_0073.
  - INST_NOP = 32'h0000_0013.
  - fetch_entry_t struct {inst[31:0], pc[31:0]}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - flush has priority over push and pop.
  - Allows push and pop simultaneously when full.
- fetch_ctrl holds the FSM, PC and error flag.

Test Plan:
- Reset, then memory holds 0x00500093 at word 0 and 0x00100113 at word 1, out_ready=1 → BOOT one cycle. Then out_pc/out_inst = 0x0/0x00500093, next cycle 0x4/0x00100113, one per cycle.
- out_ready=0 for 5 cycles after BOOT → queue fills at PCs 0x0 and 0x4, imem_addr holds at 0x8, out_valid=1. Then raise out_ready → 0x0, 0x4, 0x8 appear back-to-back with no bubble.
- Queue holding PCs 0x8 and 0xC, pulse redirect_valid with redirect_pc=0x40 → the next cycle's out_valid=0, and the cycle after gives out_pc=0x40. Neither 0x8 nor 0xC reappears after the redirect cycle; misalign_err=0.
- Word at 0x10 = 0x00000073 → ECALL is delivered at out_pc=0x10, halted=1, and imem_addr stays 0x14 indefinitely. A redirect to 0x0 clears halted and fetch resumes from 0x0.
- Redirect with redirect_pc=0x22 → fetch resumes at 0x20, misalign_err=1 and it stays 1 through later redirects. Reset clears it.
- Assert reset for one cycle mid-stream with a full queue → the next cycle gives out_valid=0 and state BOOT, and the first output after BOOT is out_pc=RESET_PC.
